rle_zigzag_expander: RTL and testbench

Run-length expander and inverse zigzag stage sitting directly downstream of the entropy decoder in the tinycodec decode path. It accepts signed (run, value) coefficient symbols, expands zero runs and end-of-block markers into 64 coefficients per 8x8 block, and writes them in raster order into a ping-pong block buffer. It then streams completed blocks with a valid/ready handshake to the dequantiser/IDCT. An input FIFO absorbs the entropy decoder's one-symbol-per-cycle output, which cannot be stalled.

---
 rtl/rle_zigzag_expander.sv | 220 ++++++++++++++++++++++
 tb/tb_rle_zigzag_expander.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rle_zigzag_expander.sv
// rtl/rle_zigzag_expander.sv - run-length expander with inverse zigzag into a ping-pong block buffer
// Symbols queue in a FIFO, expand into 64-coefficient blocks, and stream out in raster order.
module rle_zigzag_expander #(
  parameter int FIFO_DEPTH = 16,
  parameter bit ZIGZAG     = 1'b1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic signed [11:0] value_in,
  input  logic [5:0]         run_in,
  input  logic               valid_in,
  output logic               in_ready_out,
  output logic signed [11:0] coeff_out,
  output logic [5:0]         coeff_index_out,
  output logic               coeff_valid_out,
  input  logic               coeff_ready_in,
  output logic               coeff_last_out,
  output logic               overflow_out,
  output logic               run_error_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [383:0] ZZ_TABLE = {
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};

  typedef enum logic [1:0] {S_LOAD, S_ZEROS, S_VALUE, S_FILL} wr_state_e;

  logic [17:0] fifo_mem [FIFO_DEPTH];
  logic [11:0] buf_mem [128];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        fifo_full, fifo_empty, push, pop;
  logic [17:0] head;
  logic [11:0] head_value;
  logic [5:0]  head_run;

  wr_state_e   state_q, state_d;
  logic [5:0]  pos_q, pos_d;
  logic        wb_q, wb_d, rb_q, rb_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [11:0] val_q, val_d;
  logic        has_val_q, has_val_d;
  logic [1:0]  full_q, full_d;
  logic        run_err_q, run_err_d, overflow_q, overflow_d;
  logic        buf_we, set_full, clr_full;
  logic [11:0] buf_wdata;
  logic [8:0]  zz_sel;
  logic [5:0]  wr_addr;

  logic [11:0] coeff_q, coeff_d;
  logic [5:0]  idx_q, idx_d;
  logic        cvalid_q, cvalid_d, last_q, last_d;
  logic        rd_load, rd_bank;
  logic [5:0]  rd_addr;
  logic [11:0] rd_data;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = valid_in && !fifo_full;
  assign head       = fifo_mem[rd_ptr_q[AW-1:0]];
  assign head_value = head[17:6];
  assign head_run   = head[5:0];
  assign wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
  assign rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
  assign overflow_d = overflow_q | (valid_in & fifo_full);

  // Table holds entry 0 in the top bits, so index from the other end.
  assign zz_sel  = {3'b000, ~pos_q} * 9'd6;
  assign wr_addr = ZIGZAG ? ZZ_TABLE[zz_sel +: 6] : pos_q;
  assign rd_data = buf_mem[{rd_bank, rd_addr}];

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {value_in, run_in};
    if (buf_we) buf_mem[{wb_q, wr_addr}] <= buf_wdata;
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    wb_d      = wb_q;
    cnt_d     = cnt_q;
    val_d     = val_q;
    has_val_d = has_val_q;
    run_err_d = run_err_q;
    pop       = 1'b0;
    buf_we    = 1'b0;
    buf_wdata = 12'd0;
    set_full  = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (!fifo_empty && !full_q[wb_q]) begin
          pop   = 1'b1;
          val_d = head_value;
          if (pos_q == 6'd0) begin
            state_d = S_VALUE;
          end else if (head_value == 12'd0 && head_run == 6'd0) begin
            state_d = S_FILL;
          end else if (head_value == 12'd0) begin
            state_d   = S_ZEROS;
            cnt_d     = {1'b0, head_run} + 7'd1;
            has_val_d = 1'b0;
          end else if (head_run == 6'd0) begin
            state_d = S_VALUE;
          end else begin
            state_d   = S_ZEROS;
            cnt_d     = {1'b0, head_run};
            has_val_d = 1'b1;
          end
        end
      end
      S_ZEROS: begin
        buf_we = 1'b1;
        cnt_d  = cnt_q - 7'd1;
        if (cnt_q == 7'd1) state_d = has_val_q ? S_VALUE : S_LOAD;
      end
      S_VALUE: begin
        buf_we    = 1'b1;
        buf_wdata = val_q;
        state_d   = S_LOAD;
      end
      S_FILL: buf_we = 1'b1;
    endcase
    // Completing a block wins over whatever the current symbol still had pending.
    if (buf_we) begin
      pos_d = pos_q + 6'd1;
      if (pos_q == 6'd63) begin
        set_full = 1'b1;
        wb_d     = ~wb_q;
        state_d  = S_LOAD;
        if (state_q == S_ZEROS && (cnt_q != 7'd1 || has_val_q)) run_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    coeff_d  = coeff_q;
    idx_d    = idx_q;
    cvalid_d = cvalid_q;
    last_d   = last_q;
    rb_d     = rb_q;
    clr_full = 1'b0;
    rd_load  = 1'b0;
    rd_bank  = rb_q;
    rd_addr  = 6'd0;
    if (!cvalid_q) begin
      rd_load = full_q[rb_q];
    end else if (coeff_ready_in) begin
      if (idx_q == 6'd63) begin
        clr_full = 1'b1;
        rb_d     = ~rb_q;
        rd_bank  = ~rb_q;
        rd_load  = full_q[~rb_q];
        cvalid_d = full_q[~rb_q];
      end else begin
        rd_load = 1'b1;
        rd_addr = idx_q + 6'd1;
      end
    end
    if (rd_load) begin
      coeff_d  = rd_data;
      idx_d    = rd_addr;
      last_d   = (rd_addr == 6'd63);
      cvalid_d = 1'b1;
    end
    full_d = full_q;
    if (set_full) full_d[wb_q] = 1'b1;
    if (clr_full) full_d[rb_q] = 1'b0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= S_LOAD;
      pos_q      <= 6'd0;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      cnt_q      <= 7'd0;
      val_q      <= 12'd0;
      has_val_q  <= 1'b0;
      full_q     <= 2'b00;
      run_err_q  <= 1'b0;
      overflow_q <= 1'b0;
      coeff_q    <= 12'd0;
      idx_q      <= 6'd0;
      cvalid_q   <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      pos_q      <= pos_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      cnt_q      <= cnt_d;
      val_q      <= val_d;
      has_val_q  <= has_val_d;
      full_q     <= full_d;
      run_err_q  <= run_err_d;
      overflow_q <= overflow_d;
      coeff_q    <= coeff_d;
      idx_q      <= idx_d;
      cvalid_q   <= cvalid_d;
      last_q     <= last_d;
    end
  end

  assign in_ready_out    = ~fifo_full & ~rst_in;
  assign coeff_out       = coeff_q;
  assign coeff_index_out = idx_q;
  assign coeff_valid_out = cvalid_q;
  assign coeff_last_out  = last_q;
  assign overflow_out    = overflow_q;
  assign run_error_out   = run_err_q;
endmodule

// File: tb/tb_rle_zigzag_expander.sv
// tb/tb_rle_zigzag_expander.sv - scoreboard bench for rle_zigzag_expander
module tb_rle_zigzag_expander;
  logic               clk_in = 1'b0;
  logic               rst_in;
  logic signed [11:0] value_in;
  logic [5:0]         run_in;
  logic               valid_in;
  logic               in_ready_out;
  logic signed [11:0] coeff_out;
  logic [5:0]         coeff_index_out;
  logic               coeff_valid_out;
  logic               coeff_ready_in;
  logic               coeff_last_out;
  logic               overflow_out;
  logic               run_error_out;

  rle_zigzag_expander dut (
    .clk_in(clk_in), .rst_in(rst_in), .value_in(value_in), .run_in(run_in),
    .valid_in(valid_in), .in_ready_out(in_ready_out), .coeff_out(coeff_out),
    .coeff_index_out(coeff_index_out), .coeff_valid_out(coeff_valid_out),
    .coeff_ready_in(coeff_ready_in), .coeff_last_out(coeff_last_out),
    .overflow_out(overflow_out), .run_error_out(run_error_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {logic [11:0] v; logic [5:0] i;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0, n_pass = 0, cyc = 0, ready_mode = 0;
  bit   mon_en = 1'b1;
  int   zz_tab[64];
  int   m_blk[64];
  int   m_pos = 0;
  bit   m_err = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_eq(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // Scoreboard: every accepted output beat is matched against the queue head.
  always @(negedge clk_in) begin
    if (mon_en && coeff_valid_out && coeff_ready_in) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_coeff: got index %0d value %0d, expected no output", coeff_index_out, coeff_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (coeff_out === mon_e.v && coeff_index_out === mon_e.i && coeff_last_out === (mon_e.i == 6'd63))
          n_pass++;
        else
          $display("FAIL coeff: got idx %0d val %0d last %0b, expected idx %0d val %0d last %0b",
                   coeff_index_out, coeff_out, coeff_last_out, mon_e.i, $signed(mon_e.v), mon_e.i == 6'd63);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      case (ready_mode)
        0: coeff_ready_in = 1'b1;
        1: coeff_ready_in = ($urandom_range(0, 3) != 0);
        default: coeff_ready_in = 1'b0;
      endcase
    end
  end

  task automatic m_put(input int val);
    int ras[64];
    m_blk[m_pos] = val;
    m_pos++;
    if (m_pos == 64) begin
      for (int n = 0; n < 64; n++) ras[zz_tab[n]] = m_blk[n];
      for (int r = 0; r < 64; r++) exp_q.push_back('{v: 12'(ras[r]), i: 6'(r)});
      m_pos = 0;
    end
  endtask

  task automatic model_sym(input int v, input int r);
    int  nz;
    bit  done;
    if (m_pos == 0) begin
      m_put(v);
    end else if (v == 0 && r == 0) begin
      for (int k = m_pos; k < 64; k++) m_put(0);
    end else begin
      nz = (v == 0) ? r + 1 : r;
      done = 1'b0;
      for (int k = 0; k < nz; k++) begin
        if (done) begin m_err = 1'b1; break; end
        m_put(0);
        if (m_pos == 0) done = 1'b1;
      end
      if (v != 0) begin
        if (done) m_err = 1'b1;
        else m_put(v);
      end
    end
  endtask

  task automatic push(input int v, input int r, input bit wait_rdy, input bit to_model);
    int t;
    @(negedge clk_in);
    if (wait_rdy) begin
      t = 0;
      while (!in_ready_out && t < 5000) begin @(negedge clk_in); t++; end
      if (!in_ready_out) check_eq("in_ready_timeout", 0, 1);
    end
    valid_in = 1'b1;
    value_in = 12'(v);
    run_in   = 6'(r);
    if (to_model) model_sym(v, r);
    @(posedge clk_in);
    #1 valid_in = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 8000) begin @(negedge clk_in); t++; end
    check_eq("drain_remaining", exp_q.size(), 0);
    repeat (3) @(negedge clk_in);
  endtask

  initial begin
    int k, t0, v, r, t;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0)
        for (int row = (s < 8 ? s : 7); row >= (s < 8 ? 0 : s - 7); row--) begin zz_tab[k] = row * 8 + s - row; k++; end
      else
        for (int row = (s < 8 ? 0 : s - 7); row <= (s < 8 ? s : 7); row++) begin zz_tab[k] = row * 8 + s - row; k++; end
    end
    rst_in = 1'b1; valid_in = 1'b0; value_in = '0; run_in = '0; coeff_ready_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check_eq("rst_valid", coeff_valid_out, 0);
    check_eq("rst_coeff", coeff_out, 0);
    check_eq("rst_index", coeff_index_out, 0);
    check_eq("rst_last", coeff_last_out, 0);
    check_eq("rst_overflow", overflow_out, 0);
    check_eq("rst_run_error", run_error_out, 0);
    check_eq("rst_in_ready", in_ready_out, 0);
    rst_in = 1'b0;
    #1 check_eq("in_ready_after_rst", in_ready_out, 1);

    push(5, 0, 1, 1);
    t0 = cyc;
    push(0, 0, 1, 1);
    t = 0;
    while (!coeff_valid_out && t < 200) begin @(negedge clk_in); t++; end
    check_eq("first_block_latency", cyc - t0, 67);
    drain();

    push(-3, 0, 1, 1); push(7, 2, 1, 1); push(0, 0, 1, 1);
    drain();

    push(1, 0, 1, 1);
    repeat (3) push(0, 15, 1, 1);
    push(9, 14, 1, 1);
    drain();
    check_eq("exact_fill_run_error", run_error_out, 0);

    ready_mode = 1;
    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 99);
      if (k < 15) begin v = 0; r = 0; end
      else if (k < 25) begin v = 0; r = $urandom_range(1, 15); end
      else begin
        v = $urandom_range(0, 4095) - 2048;
        if (v == 0) v = 1;
        r = (k < 30) ? $urandom_range(20, 63) : $urandom_range(0, 7);
      end
      push(v, r, 1, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
    end
    if (m_pos != 0) push(0, 0, 1, 1);
    ready_mode = 0;
    drain();
    check_eq("random_run_error", run_error_out, m_err);
    check_eq("random_overflow", overflow_out, 0);

    push(1, 0, 1, 1); push(2, 50, 1, 1); push(4, 20, 1, 1);
    push(6, 0, 1, 1); push(0, 0, 1, 1);
    drain();
    check_eq("overrun_run_error", run_error_out, 1);
    check_eq("overrun_model_error", m_err, 1);

    ready_mode = 2;
    push(11, 0, 1, 1); push(0, 0, 1, 1);
    push(-7, 0, 1, 1); push(5, 3, 1, 1); push(0, 0, 1, 1);
    repeat (250) @(negedge clk_in);
    check_eq("stall_valid", coeff_valid_out, 1);
    check_eq("stall_index", coeff_index_out, 0);
    check_eq("stall_coeff", coeff_out, 11);
    push(1, 0, 0, 1);
    for (int n = 0; n < 14; n++) push(n + 2, 0, 0, 1);
    push(0, 0, 0, 1);
    @(negedge clk_in);
    check_eq("fifo_full_in_ready", in_ready_out, 0);
    check_eq("overflow_before_extra", overflow_out, 0);
    push(99, 0, 0, 0);
    @(negedge clk_in);
    check_eq("overflow_after_extra", overflow_out, 1);
    ready_mode = 0;
    drain();

    push(3, 0, 1, 1); push(0, 0, 1, 1);
    t = 0;
    while (!(coeff_valid_out && coeff_index_out == 6'd30) && t < 300) begin @(negedge clk_in); t++; end
    check_eq("reached_index_30", coeff_index_out, 30);
    #1 mon_en = 1'b0;
    rst_in = 1'b1;
    #1;
    check_eq("midrst_valid", coeff_valid_out, 0);
    check_eq("midrst_overflow", overflow_out, 0);
    check_eq("midrst_run_error", run_error_out, 0);
    exp_q.delete();
    m_pos = 0; m_err = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    mon_en = 1'b1;
    push(8, 0, 1, 1); push(0, 0, 1, 1);
    drain();
    check_eq("post_rst_run_error", run_error_out, 0);
    check_eq("post_rst_overflow", overflow_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
